// File: rtl/addsub_issue_pipe.sv
`default_nettype none
// ============================================================================
// Module   : addsub_issue_pipe
// Brief    : Two-stage valid/ready issue pipe around an external prefix adder,
//            with add/sub/carry-chain ops and a persistent carry flag.
// Revision : 1.0
// ============================================================================
module addsub_issue_pipe #(
    parameter int INPUTSIZE = 32,
    parameter int GROUPSIZE = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_op,
    input  logic [INPUTSIZE-1:0] in_a,
    input  logic [INPUTSIZE-1:0] in_b,
    output logic [INPUTSIZE-1:0] adder_a,
    output logic [INPUTSIZE-1:0] adder_b,
    output logic                 adder_c0,
    input  logic [INPUTSIZE:0]   adder_s,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [INPUTSIZE-1:0] out_result,
    output logic                 out_carry,
    output logic                 out_overflow,
    output logic                 out_zero,
    output logic                 out_negative,
    output logic                 carry_flag
);

    localparam int c_W = INPUTSIZE;

    generate
        if ((INPUTSIZE % GROUPSIZE) != 0) begin : g_bad_groupsize
            $error("INPUTSIZE must be a multiple of GROUPSIZE");
        end
    endgenerate

    logic                r_s1_valid;
    logic [1:0]          r_s1_op;
    logic [c_W-1:0]      r_s1_a;
    logic [c_W-1:0]      r_s1_b;
    logic                r_out_valid;
    logic [c_W-1:0]      r_out_result;
    logic                r_out_carry;
    logic                r_out_overflow;
    logic                r_out_zero;
    logic                r_out_negative;
    logic                r_carry_flag;

    logic                w_s2_free;
    logic                w_in_xfer;
    logic                w_advance;

    assign w_s2_free = !r_out_valid || out_ready;
    assign in_ready  = !r_s1_valid || w_s2_free;
    assign w_in_xfer = in_valid && in_ready;
    assign w_advance = r_s1_valid && w_s2_free;

    // op[0] selects subtract (invert B); op[1] selects carry-chained variants.
    assign adder_a  = r_s1_a;
    assign adder_b  = r_s1_op[0] ? ~r_s1_b : r_s1_b;
    assign adder_c0 = r_s1_op[1] ? r_carry_flag : r_s1_op[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid     <= 1'b0;
            r_s1_op        <= 2'b00;
            r_s1_a         <= '0;
            r_s1_b         <= '0;
            r_out_valid    <= 1'b0;
            r_out_result   <= '0;
            r_out_carry    <= 1'b0;
            r_out_overflow <= 1'b0;
            r_out_zero     <= 1'b0;
            r_out_negative <= 1'b0;
            r_carry_flag   <= 1'b0;
        end else begin
            if (w_advance) begin
                r_out_valid    <= 1'b1;
                r_out_result   <= adder_s[c_W-1:0];
                r_out_carry    <= adder_s[c_W];
                r_out_overflow <= (adder_a[c_W-1] == adder_b[c_W-1]) &&
                                  (adder_s[c_W-1] != adder_a[c_W-1]);
                r_out_zero     <= (adder_s[c_W-1:0] == '0);
                r_out_negative <= adder_s[c_W-1];
                r_carry_flag   <= adder_s[c_W];
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_in_xfer) begin
                r_s1_valid <= 1'b1;
                r_s1_op    <= in_op;
                r_s1_a     <= in_a;
                r_s1_b     <= in_b;
            end else if (w_advance) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign out_result   = r_out_result;
    assign out_carry    = r_out_carry;
    assign out_overflow = r_out_overflow;
    assign out_zero     = r_out_zero;
    assign out_negative = r_out_negative;
    assign carry_flag   = r_carry_flag;

endmodule
`default_nettype wire

// File: tb/tb_addsub_issue_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_addsub_issue_pipe
// Brief    : Randomised + directed bench for addsub_issue_pipe with an
//            arithmetic reference model and an ideal adder behind the DUT.
// Revision : 1.0
// ============================================================================
module tb_addsub_issue_pipe;

    localparam int c_W = 32;
    localparam logic [1:0] c_ADD = 2'b00, c_SUB = 2'b01, c_ADDC = 2'b10, c_SUBB = 2'b11;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [1:0]     in_op;
    logic [c_W-1:0] in_a, in_b;
    logic [c_W-1:0] adder_a, adder_b;
    logic           adder_c0;
    logic [c_W:0]   adder_s;
    logic           out_valid, out_ready;
    logic [c_W-1:0] out_result;
    logic           out_carry, out_overflow, out_zero, out_negative, carry_flag;

    addsub_issue_pipe #(.INPUTSIZE(c_W), .GROUPSIZE(4)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b),
        .adder_a(adder_a), .adder_b(adder_b), .adder_c0(adder_c0), .adder_s(adder_s),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_carry(out_carry), .out_overflow(out_overflow), .out_zero(out_zero),
        .out_negative(out_negative), .carry_flag(carry_flag)
    );

    // Ideal stand-in for the prefix adder.
    assign adder_s = {1'b0, adder_a} + {1'b0, adder_b} + {{c_W{1'b0}}, adder_c0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [c_W-1:0] result;
        logic           carry;
        logic           ovf;
    } exp_t;

    exp_t     r_expq[$];
    logic     r_model_cf;
    int       n_tests;
    int       n_fail;
    logic     r_seen_ready;
    int       n_accepted;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic: unsigned/signed integer math on 64-bit values.
    task automatic model_push(input logic [1:0] op, input logic [c_W-1:0] a, input logic [c_W-1:0] b);
        longint ua, ub, sa, sb, full, sres, cin;
        exp_t e;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op[0] == 1'b0) begin
            cin     = (op[1] && r_model_cf) ? 64'd1 : 64'd0;
            full    = ua + ub + cin;
            e.carry = (full >= 64'h1_0000_0000);
            sres    = sa + sb + cin;
        end else begin
            cin     = (op[1] && !r_model_cf) ? 64'd1 : 64'd0;
            full    = ua - ub - cin;
            e.carry = (ua >= ub + cin);
            sres    = sa - sb - cin;
        end
        e.result   = full[c_W-1:0];
        e.ovf      = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
        r_model_cf = e.carry;
        r_expq.push_back(e);
        n_accepted++;
    endtask

    task automatic retire_check();
        exp_t e;
        if (r_expq.size() == 0) begin
            check("unexpected_out", 64'(out_valid), 64'd0);
        end else begin
            e = r_expq.pop_front();
            check("result",   64'(out_result),   64'(e.result));
            check("carry",    64'(out_carry),    64'(e.carry));
            check("overflow", 64'(out_overflow), 64'(e.ovf));
            check("zero",     64'(out_zero),     64'(e.result == 0));
            check("negative", 64'(out_negative), 64'(e.result[c_W-1]));
            check("carry_flag", 64'(carry_flag), 64'(e.carry));
        end
    endtask

    // One clock: drive at the negedge, account for transfers, advance to next negedge.
    task automatic cycle(input logic v, input logic [1:0] op, input logic [c_W-1:0] a,
                         input logic [c_W-1:0] b, input logic rdy);
        in_valid  = v;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        out_ready = rdy;
        #1;
        r_seen_ready = in_ready;
        if (in_valid && in_ready) model_push(op, a, b);
        if (out_valid && out_ready) retire_check();
        @(negedge clk);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        r_expq.delete();
        r_model_cf = 1'b0;
    endtask

    function automatic logic [c_W-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    logic [c_W-1:0] r_hold_result;
    logic           r_stall_ok;

    initial begin
        n_tests = 0; n_fail = 0; n_accepted = 0;
        r_model_cf = 1'b0;
        rst = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_a = '0; in_b = '0; out_ready = 1'b1;
        @(negedge clk);
        do_reset();
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_carry_flag", 64'(carry_flag), 64'd0);
        check("rst_result", 64'({out_result, out_carry, out_overflow, out_zero, out_negative}), 64'd0);

        // Latency and basic arithmetic
        cycle(1'b1, c_ADD, 32'd5, 32'd3, 1'b0);
        check("lat_edge1", 64'(out_valid), 64'd0);
        cycle(1'b0, c_ADD, 32'd0, 32'd0, 1'b0);
        check("lat_edge2", 64'(out_valid), 64'd1);
        check("add_5_3", 64'(out_result), 64'd8);
        cycle(1'b1, c_SUB, 32'd3, 32'd5, 1'b1);
        cycle(1'b1, c_SUB, 32'd5, 32'd5, 1'b1);
        cycle(1'b1, c_ADD, 32'h7FFF_FFFF, 32'd1, 1'b1);
        cycle(1'b1, c_ADD, 32'hFFFF_FFFF, 32'd1, 1'b1);
        check("b2b_ready0", 64'(r_seen_ready), 64'd1);
        cycle(1'b1, c_ADDC, 32'd0, 32'd0, 1'b1);
        check("b2b_ready1", 64'(r_seen_ready), 64'd1);
        cycle(1'b1, c_SUBB, 32'd0, 32'd0, 1'b1);
        check("b2b_ready2", 64'(r_seen_ready), 64'd1);
        for (int i = 0; i < 4; i++) cycle(1'b0, c_ADD, 32'd0, 32'd0, 1'b1);
        check("directed_drain", 64'(r_expq.size()), 64'd0);

        // Backpressure: 3 ops offered while the sink stalls for 4 cycles
        n_accepted = 0;
        r_stall_ok = 1'b1;
        cycle(1'b1, c_ADD, 32'd10, 32'd20, 1'b0);
        cycle(1'b1, c_SUB, 32'd100, 32'd1, 1'b0);
        r_hold_result = out_result;
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, c_ADDC, 32'd7, 32'd7, 1'b0);
            check("bp_in_ready_low", 64'(r_seen_ready), 64'd0);
            if (out_result !== r_hold_result || !out_valid) r_stall_ok = 1'b0;
        end
        check("bp_accepted", 64'(n_accepted), 64'd2);
        check("bp_stable", 64'(r_stall_ok), 64'd1);
        while (!r_seen_ready) cycle(1'b1, c_ADDC, 32'd7, 32'd7, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, c_ADD, 32'd0, 32'd0, 1'b1);
        check("bp_drain", 64'(r_expq.size()), 64'd0);

        // Reset with both stages full and carry_flag set
        cycle(1'b1, c_ADD, 32'hFFFF_FFFF, 32'd1, 1'b0);
        cycle(1'b1, c_ADD, 32'hFFFF_FFFF, 32'd2, 1'b0);
        cycle(1'b1, c_ADD, 32'd1, 32'd1, 1'b0);
        check("pre_rst_cf", 64'(carry_flag), 64'd1);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        r_expq.delete();
        r_model_cf = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check("mid_rst_carry_flag", 64'(carry_flag), 64'd0);
        r_stall_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, c_ADD, 32'd0, 32'd0, 1'b1);
            if (out_valid) r_stall_ok = 1'b0;
        end
        check("no_stale_out", 64'(r_stall_ok), 64'd1);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                  rand_operand(), rand_operand(), ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 50 && r_expq.size() != 0; i++) cycle(1'b0, c_ADD, 32'd0, 32'd0, 1'b1);
        check("final_drain", 64'(r_expq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
